// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic {
    OpMul = 1'b0,
    OpDiv = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_fix.sv
// Turns an unsigned magnitude quotient/remainder into the final signed (Euclidean) result.
module muldiv_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] q_raw,
  input  logic [W-1:0] r_raw,
  input  logic [W-1:0] y_mag,
  input  logic         x_neg,
  input  logic         y_neg,
  input  logic         sgn,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  always_comb begin
    quot = q_raw;
    rem  = r_raw;
    if (sgn) begin
      // A negative dividend with a nonzero remainder is pushed one step toward -inf/+inf
      // so that the remainder becomes non-negative.
      if (x_neg && (r_raw != '0)) begin
        rem  = y_mag - r_raw;
        quot = y_neg ? (q_raw + W'(1)) : -(q_raw + W'(1));
      end else if (x_neg ^ y_neg) begin
        quot = -q_raw;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 sequential multiplier/divider: W BUSY cycles per operation, stall held until DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           op,
  input  logic           sgn,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           stall,
  output logic [2*W-1:0] z,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem,
  output logic           dz
);

  localparam int unsigned CntW = $clog2(W);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  op_e             op_q;
  logic            sgn_q, xneg_q, yneg_q, yzero_q;
  logic [W-1:0]    x_q, m_q, hi_q, lo_q;

  logic            xneg, yneg;
  logic [W-1:0]    xmag, ymag;
  logic [W:0]      sum, sh;
  logic [W-1:0]    diff, hi_d, lo_d;
  logic [2*W-1:0]  prod, z_next;
  logic [W-1:0]    fix_quot, fix_rem;

  assign xneg  = sgn & x[W-1];
  assign yneg  = sgn & y[W-1];
  assign xmag  = xneg ? -x : x;
  assign ymag  = yneg ? -y : y;
  assign stall = run & (state_q != StDone);

  // Multiply: shift-add with the multiplier in lo. Divide: restoring, quotient shifts into lo.
  always_comb begin
    sum  = '0;
    sh   = '0;
    diff = '0;
    hi_d = hi_q;
    lo_d = lo_q;
    if (op_q == OpMul) begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      hi_d = sum[W:1];
      lo_d = {sum[0], lo_q[W-1:1]};
    end else begin
      sh   = {hi_q, lo_q[W-1]};
      diff = sh[W-1:0] - m_q;
      if (sh >= {1'b0, m_q}) begin
        hi_d = diff;
        lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_d = sh[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b0};
      end
    end
  end

  assign prod   = {hi_d, lo_d};
  assign z_next = (xneg_q ^ yneg_q) ? -prod : prod;

  muldiv_fix #(.W(W)) u_fix (
    .q_raw (lo_d),
    .r_raw (hi_d),
    .y_mag (m_q),
    .x_neg (xneg_q),
    .y_neg (yneg_q),
    .sgn   (sgn_q),
    .quot  (fix_quot),
    .rem   (fix_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      z       <= '0;
      quot    <= '0;
      rem     <= '0;
      dz      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StBusy;
            op_q    <= op_e'(op);
            sgn_q   <= sgn;
            xneg_q  <= xneg;
            yneg_q  <= yneg;
            yzero_q <= (y == '0);
            x_q     <= x;
            hi_q    <= '0;
            m_q     <= (op_e'(op) == OpMul) ? xmag : ymag;
            lo_q    <= (op_e'(op) == OpMul) ? ymag : xmag;
          end
        end
        StBusy: begin
          if (!run) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == CntW'(W - 1)) begin
              state_q <= StDone;
              cnt_q   <= '0;
              if (op_q == OpMul) begin
                z <= z_next;
              end else begin
                dz   <= yzero_q;
                quot <= yzero_q ? '1 : fix_quot;
                rem  <= yzero_q ? x_q : fix_rem;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
